alu_arbiter: RTL and testbench

- Shares one combinational Hack-style ALU (16-bit x/y, 6-bit op, result/zr/ng) between two requesters.
- Each requester has a valid/ready command port and a valid/ready response port.
- Commands are granted round-robin, registered onto the ALU inputs, and the ALU outputs are captured one cycle later into the owning requester's response buffer.
- Sits between the instruction-issue logic and the ALU instance; the ALU stays unmodified.

---
 rtl/alu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational Hack-style ALU between two requesters. Commands
//   are granted round-robin and registered onto the ALU inputs. One cycle
//   later the ALU outputs are captured into the owning requester's
//   single-entry response buffer.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqN_valid/ready/x/y/op        command port of requester N (N = 0, 1)
//   respN_valid/ready/result/zr/ng response port of requester N
//   alu_x/alu_y/alu_op             registered operands/control to the ALU
//   alu_result/alu_zr/alu_ng       combinational outputs from the ALU
//   stat0_cnt/stat1_cnt            saturating accept counters; present only
//                                  when ALU_ARB_STATS_EN is defined
//
// Optional feature macro: ALU_ARB_STATS_EN
module alu_arbiter #(
    parameter int W   = 16,
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_x,
    input  logic [W-1:0]   req0_y,
    input  logic [OPW-1:0] req0_op,
    output logic           resp0_valid,
    input  logic           resp0_ready,
    output logic [W-1:0]   resp0_result,
    output logic           resp0_zr,
    output logic           resp0_ng,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_x,
    input  logic [W-1:0]   req1_y,
    input  logic [OPW-1:0] req1_op,
    output logic           resp1_valid,
    input  logic           resp1_ready,
    output logic [W-1:0]   resp1_result,
    output logic           resp1_zr,
    output logic           resp1_ng,
    output logic [W-1:0]   alu_x,
    output logic [W-1:0]   alu_y,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_zr,
    input  logic           alu_ng
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]    stat0_cnt,
    output logic [15:0]    stat1_cnt
`endif
);

    logic           last_q;       // requester granted most recently
    logic           infl_vld_q;   // an op is on the ALU this cycle
    logic           infl_tag_q;   // owner of that op
    logic [W-1:0]   alu_x_q, alu_y_q, alu_x_d, alu_y_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;

    logic           resp0_vld_q, resp0_zr_q, resp0_ng_q;
    logic [W-1:0]   resp0_res_q;
    logic           resp1_vld_q, resp1_zr_q, resp1_ng_q;
    logic [W-1:0]   resp1_res_q;

    logic elig0, elig1, grant0, grant1, xfer, cap0, cap1;

    // A requester may issue only if it has no op on the ALU and its response
    // buffer will have room when that op is captured.
    always_comb begin
        elig0  = req0_valid && !(infl_vld_q && !infl_tag_q) && (!resp0_vld_q || resp0_ready);
        elig1  = req1_valid && !(infl_vld_q &&  infl_tag_q) && (!resp1_vld_q || resp1_ready);
        grant0 = elig0 && (!elig1 || last_q);
        grant1 = elig1 && (!elig0 || !last_q);
    end

    assign xfer = grant0 || grant1;

    // Ready is forced low while reset is asserted so no command is seen as
    // accepted during reset.
    assign req0_ready = grant0 && rst_n;
    assign req1_ready = grant1 && rst_n;

    always_comb begin
        alu_x_d  = grant1 ? req1_x  : req0_x;
        alu_y_d  = grant1 ? req1_y  : req0_y;
        alu_op_d = grant1 ? req1_op : req0_op;
    end

    // Issue: register the granted command onto the ALU inputs. The ALU
    // inputs hold their value when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            infl_vld_q <= 1'b0;
            infl_tag_q <= 1'b0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            alu_op_q   <= '0;
        end else begin
            infl_vld_q <= xfer;
            if (xfer) begin
                infl_tag_q <= grant1;
                last_q     <= grant1;
                alu_x_q    <= alu_x_d;
                alu_y_q    <= alu_y_d;
                alu_op_q   <= alu_op_d;
            end
        end
    end

    assign cap0 = infl_vld_q && !infl_tag_q;
    assign cap1 = infl_vld_q &&  infl_tag_q;

    // Capture: a capture takes priority over a drain on the same edge, so the
    // buffer reloads and stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0_vld_q <= 1'b0;
            resp0_res_q <= '0;
            resp0_zr_q  <= 1'b0;
            resp0_ng_q  <= 1'b0;
            resp1_vld_q <= 1'b0;
            resp1_res_q <= '0;
            resp1_zr_q  <= 1'b0;
            resp1_ng_q  <= 1'b0;
        end else begin
            if (cap0) begin
                resp0_vld_q <= 1'b1;
                resp0_res_q <= alu_result;
                resp0_zr_q  <= alu_zr;
                resp0_ng_q  <= alu_ng;
            end else if (resp0_vld_q && resp0_ready) begin
                resp0_vld_q <= 1'b0;
            end
            if (cap1) begin
                resp1_vld_q <= 1'b1;
                resp1_res_q <= alu_result;
                resp1_zr_q  <= alu_zr;
                resp1_ng_q  <= alu_ng;
            end else if (resp1_vld_q && resp1_ready) begin
                resp1_vld_q <= 1'b0;
            end
        end
    end

    assign alu_x        = alu_x_q;
    assign alu_y        = alu_y_q;
    assign alu_op       = alu_op_q;
    assign resp0_valid  = resp0_vld_q;
    assign resp0_result = resp0_res_q;
    assign resp0_zr     = resp0_zr_q;
    assign resp0_ng     = resp0_ng_q;
    assign resp1_valid  = resp1_vld_q;
    assign resp1_result = resp1_res_q;
    assign resp1_zr     = resp1_zr_q;
    assign resp1_ng     = resp1_ng_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat0_q, stat1_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            if (grant0) stat0_q <= sat_inc(stat0_q);
            if (grant1) stat1_q <= sat_inc(stat1_q);
        end
    end

    assign stat0_cnt = stat0_q;
    assign stat1_cnt = stat1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    localparam int W   = 16;
    localparam int OPW = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zr, resp0_ng;
    logic [W-1:0]   req0_x, req0_y, resp0_result;
    logic [OPW-1:0] req0_op;
    logic           req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zr, resp1_ng;
    logic [W-1:0]   req1_x, req1_y, resp1_result;
    logic [OPW-1:0] req1_op;
    logic [W-1:0]   alu_x, alu_y, alu_result;
    logic [OPW-1:0] alu_op;
    logic           alu_zr, alu_ng;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]    stat0_cnt, stat1_cnt;
`endif

    alu_arbiter #(.W(W), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp0_zr(resp0_zr), .resp0_ng(resp0_ng),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .resp1_zr(resp1_zr), .resp1_ng(resp1_ng),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zr(alu_zr), .alu_ng(alu_ng)
`ifdef ALU_ARB_STATS_EN
        , .stat0_cnt(stat0_cnt), .stat1_cnt(stat1_cnt)
`endif
    );

    // Hack ALU: op = {zx, nx, zy, ny, f, no}
    logic [W-1:0] ax, ay, ao;
    always_comb begin
        ax = alu_op[5] ? '0 : alu_x;
        if (alu_op[4]) ax = ~ax;
        ay = alu_op[3] ? '0 : alu_y;
        if (alu_op[2]) ay = ~ay;
        ao = alu_op[1] ? ax + ay : ax & ay;
        if (alu_op[0]) ao = ~ao;
        alu_result = ao;
        alu_zr     = (ao == '0);
        alu_ng     = ao[W-1];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit rq, input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [OPW-1:0] op);
        if (rq) begin
            req1_valid = v; req1_x = x; req1_y = y; req1_op = op;
        end else begin
            req0_valid = v; req0_x = x; req0_y = y; req0_op = op;
        end
    endtask

    typedef struct {
        bit             rq;
        logic [W-1:0]   x, y;
        logic [OPW-1:0] op;
        logic [W-1:0]   res;
        bit             zr, ng;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b0, 16'h0001, 16'h0001, 6'b101010, 16'h0000, 1'b1, 1'b0}; // 0
        tbl[1] = '{1'b1, 16'h0005, 16'h0003, 6'b000010, 16'h0008, 1'b0, 1'b0}; // x+y
        tbl[2] = '{1'b0, 16'h0005, 16'h0003, 6'b010011, 16'h0002, 1'b0, 1'b0}; // x-y
        tbl[3] = '{1'b1, 16'h0003, 16'h0005, 6'b010011, 16'hFFFE, 1'b0, 1'b1}; // x-y < 0
        tbl[4] = '{1'b0, 16'h00F0, 16'h0F0F, 6'b000000, 16'h0000, 1'b1, 1'b0}; // x&y
        tbl[5] = '{1'b1, 16'h00F0, 16'h0F0F, 6'b010101, 16'h0FFF, 1'b0, 1'b0}; // x|y
        tbl[6] = '{1'b0, 16'h1234, 16'h5555, 6'b001100, 16'h1234, 1'b0, 1'b0}; // x
        tbl[7] = '{1'b1, 16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1}; // overflow

        req0_valid = 0; req0_x = '0; req0_y = '0; req0_op = '0; resp0_ready = 1;
        req1_valid = 0; req1_x = '0; req1_y = '0; req1_op = '0; resp1_ready = 1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        req0_valid = 1; req1_valid = 1;
        #2;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_resp0_valid", resp0_valid, 0);
        check("rst_resp1_valid", resp1_valid, 0);
        check("rst_alu_x", alu_x, 0);
        check("rst_alu_op", alu_op, 0);
        req0_valid = 0; req1_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Isolated commands: accept, 2-edge latency, captured result
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].rq, 1'b1, tbl[i].x, tbl[i].y, tbl[i].op);
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), tbl[i].rq ? req1_ready : req0_ready, 1);
            @(posedge clk); #1;
            drive(tbl[i].rq, 1'b0, tbl[i].x, tbl[i].y, tbl[i].op);
            check($sformatf("tbl%0d_alu_x", i), alu_x, tbl[i].x);
            check($sformatf("tbl%0d_alu_op", i), alu_op, tbl[i].op);
            check($sformatf("tbl%0d_early_valid", i), tbl[i].rq ? resp1_valid : resp0_valid, 0);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_valid", i), tbl[i].rq ? resp1_valid : resp0_valid, 1);
            check($sformatf("tbl%0d_result", i), tbl[i].rq ? resp1_result : resp0_result, tbl[i].res);
            check($sformatf("tbl%0d_zr", i), tbl[i].rq ? resp1_zr : resp0_zr, tbl[i].zr);
            check($sformatf("tbl%0d_ng", i), tbl[i].rq ? resp1_ng : resp0_ng, tbl[i].ng);
        end

        // Back-to-back: both requesters valid every cycle, grants alternate
        drive(1'b0, 1'b1, 16'h0001, 16'h0001, 6'b111111);
        drive(1'b1, 1'b1, 16'h0001, 16'h0001, 6'b111010);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("b2b%0d_ready0", k), req0_ready, (k % 2 == 0));
            check($sformatf("b2b%0d_ready1", k), req1_ready, (k % 2 == 1));
            check($sformatf("b2b%0d_resp0_valid", k), resp0_valid, (k >= 2 && k % 2 == 0));
            if (k >= 1)
                check($sformatf("b2b%0d_resp1_valid", k), resp1_valid, (k >= 3 && k % 2 == 1));
            if (k >= 2 && k % 2 == 0) begin
                check($sformatf("b2b%0d_resp0", k), {resp0_result, resp0_zr, resp0_ng}, {16'h0001, 1'b0, 1'b0});
            end
            if (k >= 3 && k % 2 == 1) begin
                check($sformatf("b2b%0d_resp1", k), {resp1_result, resp1_zr, resp1_ng}, {16'hFFFF, 1'b0, 1'b1});
            end
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        repeat (3) @(posedge clk); #1;

        // Backpressure on requester 0 while requester 1 keeps streaming
        resp0_ready = 0;
        drive(1'b0, 1'b1, 16'h0005, 16'h0003, 6'b000010);
        drive(1'b1, 1'b1, 16'h0001, 16'h0001, 6'b111111);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_ready0", c), req0_ready, (c == 0));
            check($sformatf("bp%0d_ready1", c), req1_ready, (c % 2 == 1));
            if (c >= 2) begin
                check($sformatf("bp%0d_resp0_valid", c), resp0_valid, 1);
                check($sformatf("bp%0d_resp0_result", c), resp0_result, 16'h0008);
            end
            @(posedge clk); #1;
            if (c == 0) req0_op = 6'b010011;
        end
        resp0_ready = 1; req1_valid = 0;
        @(negedge clk);
        check("bp_drain_ready0", req0_ready, 1);
        check("bp_drain_old_result", resp0_result, 16'h0008);
        @(posedge clk); #1;
        req0_valid = 0;
        check("bp_drain_valid", resp0_valid, 0);
        @(posedge clk); #1;
        check("bp_second_valid", resp0_valid, 1);
        check("bp_second_result", resp0_result, 16'h0002);
        repeat (2) @(posedge clk); #1;

        // Asynchronous reset between accept and capture
        drive(1'b0, 1'b1, 16'h0001, 16'h0001, 6'b111111);
        @(negedge clk);
        check("ar_accept_ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        check("ar_alu_op_loaded", alu_op, 6'b111111);
        #2 rst_n = 1'b0;
        req0_valid = 1; req1_valid = 1;
        #1;
        check("ar_req0_ready", req0_ready, 0);
        check("ar_req1_ready", req1_ready, 0);
        check("ar_alu_x", alu_x, 0);
        check("ar_alu_y", alu_y, 0);
        check("ar_alu_op", alu_op, 0);
        check("ar_resp0_result", resp0_result, 0);
        check("ar_resp1_result", resp1_result, 0);
        @(posedge clk); #1;
        check("ar_capture_blocked", resp0_valid, 0);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("ar_no_stale0", resp0_valid, 0);
        check("ar_no_stale1", resp1_valid, 0);

        // First tie after reset goes to requester 0; then 5 vs 3 accepts
        drive(1'b0, 1'b1, 16'h0001, 16'h0001, 6'b111111);
        drive(1'b1, 1'b1, 16'h0001, 16'h0001, 6'b111010);
        for (int k = 0; k < 10; k++) begin
            if (k == 6) req1_valid = 0;
            @(negedge clk);
            check($sformatf("st%0d_ready0", k), req0_ready, (k % 2 == 0));
            check($sformatf("st%0d_ready1", k), req1_ready, (k < 6 && k % 2 == 1));
            @(posedge clk); #1;
        end
        req0_valid = 0;
        repeat (3) @(posedge clk); #1;
`ifdef ALU_ARB_STATS_EN
        check("stat0_cnt", stat0_cnt, 16'd5);
        check("stat1_cnt", stat1_cnt, 16'd3);
        force dut.stat0_q = 16'hFFFF;
        #1 release dut.stat0_q;
        req0_valid = 1;
        @(negedge clk);
        check("sat_ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        check("stat0_saturated", stat0_cnt, 16'hFFFF);
        check("stat1_unchanged", stat1_cnt, 16'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
